// File: rtl/instr_encode_loader_pkg.sv
// Shared types and opcode constants for the R/I/U instruction encode-and-load block.
package instr_encode_loader_pkg;

  typedef enum logic [1:0] {
    FMT_R   = 2'd0,
    FMT_I   = 2'd1,
    FMT_U   = 2'd2,
    FMT_BAD = 2'd3
  } fmt_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [6:0] OP_REG = 7'h33;
  localparam logic [6:0] OP_IMM = 7'h13;
  localparam logic [6:0] OP_LUI = 7'h37;

endpackage

// File: rtl/instr_encode_loader_if.sv
// Field-bundle handshake and instruction-memory write bus for the encode loader.
interface instr_encode_loader_if #(
  parameter int ADDR_W = 8
) ();
  import instr_encode_loader_pkg::*;

  logic              in_valid;
  logic              in_ready;
  fmt_e              in_fmt;
  logic              in_last;
  logic [6:0]        funct7;
  logic [4:0]        rs2;
  logic [4:0]        rs1;
  logic [2:0]        funct3;
  logic [4:0]        rd;
  logic [6:0]        opcode;
  logic [11:0]       imm12;
  logic [19:0]       imm20;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  modport master (
    output in_valid, in_fmt, in_last, funct7, rs2, rs1, funct3, rd, opcode, imm12, imm20,
    input  in_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  in_valid, in_fmt, in_last, funct7, rs2, rs1, funct3, rd, opcode, imm12, imm20,
    output in_ready, imem_we, imem_addr, imem_wdata
  );

endinterface

// File: rtl/instr_encode_loader_pack.sv
// Combinational packer: format plus instruction fields into one 32-bit RV32 word.
module instr_pack
  import instr_encode_loader_pkg::*;
(
  input  fmt_e        fmt_i,
  input  logic [6:0]  funct7_i,
  input  logic [4:0]  rs2_i,
  input  logic [4:0]  rs1_i,
  input  logic [2:0]  funct3_i,
  input  logic [4:0]  rd_i,
  input  logic [6:0]  opcode_i,
  input  logic [11:0] imm12_i,
  input  logic [19:0] imm20_i,
  output logic [31:0] word_o,
  output logic        bad_o
);

  always_comb begin
    word_o = 32'h0;
    bad_o  = 1'b0;
    case (fmt_i)
      FMT_R:   word_o = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, opcode_i};
      FMT_I:   word_o = {imm12_i, rs1_i, funct3_i, rd_i, opcode_i};
      FMT_U:   word_o = {imm20_i, rd_i, opcode_i};
      default: bad_o  = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_encode_loader.sv
// Accepts field bundles, encodes them and writes one word per accept into imem
// through a single registered write stage.
module instr_encode_loader
  import instr_encode_loader_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  instr_encode_loader_if.slave  bus,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic [ADDR_W:0]       count_o
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] wptr_q, wptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              err_q, err_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       word;
  logic              bad;
  logic              accept;

  instr_pack u_pack (
    .fmt_i    (bus.in_fmt),
    .funct7_i (bus.funct7),
    .rs2_i    (bus.rs2),
    .rs1_i    (bus.rs1),
    .funct3_i (bus.funct3),
    .rd_i     (bus.rd),
    .opcode_i (bus.opcode),
    .imm12_i  (bus.imm12),
    .imm20_i  (bus.imm20),
    .word_o   (word),
    .bad_o    (bad)
  );

  assign bus.in_ready = (state_q == LOAD) && !start_i;
  assign accept       = bus.in_valid && bus.in_ready;

  // start outranks everything; a write already registered still drains next cycle.
  always_comb begin
    state_d = state_q;
    wptr_d  = wptr_q;
    count_d = count_q;
    err_d   = err_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    if (start_i) begin
      state_d = LOAD;
      wptr_d  = '0;
      count_d = '0;
      err_d   = 1'b0;
    end else if (accept) begin
      if (bad) begin
        err_d = 1'b1;
        if (bus.in_last) state_d = DONE;
      end else begin
        we_d    = 1'b1;
        addr_d  = wptr_q;
        wdata_d = word;
        count_d = count_q + (ADDR_W+1)'(1);
        if (wptr_q != LAST_ADDR) wptr_d = wptr_q + ADDR_W'(1);
        if (bus.in_last || wptr_q == LAST_ADDR) state_d = DONE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      wptr_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      count_q <= count_d;
      err_q   <= err_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign bus.imem_we    = we_q;
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = wdata_q;
  assign busy_o         = (state_q == LOAD);
  assign done_o         = (state_q == DONE);
  assign err_o          = err_q;
  assign count_o        = count_q;

endmodule

// File: tb/tb_instr_encode_loader.sv
// Scenario bench for instr_encode_loader: expected writes go to a scoreboard queue
// and are popped by a monitor whenever imem_we is seen.
module tb_instr_encode_loader;
  import instr_encode_loader_pkg::*;

  localparam int ADDR_W = 8;
  localparam int DEPTH  = 4;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic busy, done, err;
  logic [ADDR_W:0] count;
  int total_cnt = 0;
  int bad_cnt = 0;
  exp_t exp_q[$];

  instr_encode_loader_if #(.ADDR_W(ADDR_W)) bus ();

  instr_encode_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk     (clk),
    .rst     (rst),
    .start_i (start),
    .bus     (bus),
    .busy_o  (busy),
    .done_o  (done),
    .err_o   (err),
    .count_o (count)
  );

  always #5 clk = ~clk;

  // Every observed write must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && bus.imem_we) begin
      total_cnt++;
      if (exp_q.size() == 0) begin
        bad_cnt++;
        $display("[TB] FAIL unexpected_write: got addr=%0d data=%h want no write", bus.imem_addr, bus.imem_wdata);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (bus.imem_addr !== e.addr || bus.imem_wdata !== e.data) begin
          bad_cnt++;
          $display("[TB] FAIL write: got addr=%0d data=%h want addr=%0d data=%h",
                   bus.imem_addr, bus.imem_wdata, e.addr, e.data);
        end
      end
    end
  end

  function automatic logic [31:0] model_word(input fmt_e f, input logic [6:0] f7, input logic [4:0] r2,
                                             input logic [4:0] r1, input logic [2:0] f3, input logic [4:0] d,
                                             input logic [6:0] op, input logic [11:0] i12, input logic [19:0] i20);
    logic [31:0] w;
    w = {25'h0, op} | ({27'h0, d} << 7);
    if (f == FMT_R) w = w | ({29'h0, f3} << 12) | ({27'h0, r1} << 15) | ({27'h0, r2} << 20) | ({25'h0, f7} << 25);
    if (f == FMT_I) w = w | ({29'h0, f3} << 12) | ({27'h0, r1} << 15) | ({20'h0, i12} << 20);
    if (f == FMT_U) w = w | ({12'h0, i20} << 12);
    return w;
  endfunction

  task automatic drive(input fmt_e f, input logic [6:0] f7, input logic [4:0] r2, input logic [4:0] r1,
                       input logic [2:0] f3, input logic [4:0] d, input logic [6:0] op,
                       input logic [11:0] i12, input logic [19:0] i20, input logic last);
    bus.in_valid = 1'b1;
    bus.in_fmt   = f;
    bus.funct7   = f7;
    bus.rs2      = r2;
    bus.rs1      = r1;
    bus.funct3   = f3;
    bus.rd       = d;
    bus.opcode   = op;
    bus.imm12    = i12;
    bus.imm20    = i20;
    bus.in_last  = last;
  endtask

  task automatic idle_inputs();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic send_r(input logic [4:0] d, input logic last, input logic [ADDR_W-1:0] exp_addr);
    drive(FMT_R, 7'h20, 5'd9, 5'd17, 3'd5, d, OP_REG, 12'hABC, 20'hDEAD0, last);
    exp_q.push_back('{exp_addr, model_word(FMT_R, 7'h20, 5'd9, 5'd17, 3'd5, d, OP_REG, 12'hABC, 20'hDEAD0)});
    @(negedge clk);
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    total_cnt++; if (bus.imem_we !== 1'b0) begin bad_cnt++; $display("[TB] FAIL rst_we: got %b want 0", bus.imem_we); end
    total_cnt++; if (bus.imem_addr !== '0) begin bad_cnt++; $display("[TB] FAIL rst_addr: got %0d want 0", bus.imem_addr); end
    total_cnt++; if (bus.imem_wdata !== 32'h0) begin bad_cnt++; $display("[TB] FAIL rst_wdata: got %h want 0", bus.imem_wdata); end
    total_cnt++; if ({done, err, busy, bus.in_ready} !== 4'b0) begin bad_cnt++; $display("[TB] FAIL rst_status: got %b want 0000", {done, err, busy, bus.in_ready}); end
    total_cnt++; if (count !== '0) begin bad_cnt++; $display("[TB] FAIL rst_count: got %0d want 0", count); end
    rst = 1'b0;
    @(negedge clk);
    total_cnt++; if (bus.in_ready !== 1'b0) begin bad_cnt++; $display("[TB] FAIL idle_ready: got %b want 0", bus.in_ready); end
  endtask

  task automatic test_r_word();
    do_start();
    drive(FMT_R, 7'h00, 5'd2, 5'd1, 3'd0, 5'd3, 7'h33, 12'h0, 20'h0, 1'b0);
    exp_q.push_back('{8'd0, 32'h002081B3});
    @(negedge clk);
    idle_inputs();
    total_cnt++; if (bus.imem_we !== 1'b1) begin bad_cnt++; $display("[TB] FAIL r_we: got %b want 1", bus.imem_we); end
    total_cnt++; if (count !== 9'd1) begin bad_cnt++; $display("[TB] FAIL r_count: got %0d want 1", count); end
    @(negedge clk);
    total_cnt++; if (bus.imem_we !== 1'b0) begin bad_cnt++; $display("[TB] FAIL r_pulse: got %b want 0", bus.imem_we); end
  endtask

  task automatic test_back_to_back();
    do_start();
    drive(FMT_I, 7'h7F, 5'd31, 5'd0, 3'd0, 5'd5, 7'h13, 12'hFFF, 20'hFFFFF, 1'b0);
    exp_q.push_back('{8'd0, 32'hFFF00293});
    @(negedge clk);
    drive(FMT_U, 7'h7F, 5'd31, 5'd31, 3'd7, 5'd7, 7'h37, 12'hFFF, 20'h12345, 1'b0);
    exp_q.push_back('{8'd1, 32'h123453B7});
    total_cnt++; if (bus.imem_we !== 1'b1) begin bad_cnt++; $display("[TB] FAIL b2b_we0: got %b want 1", bus.imem_we); end
    @(negedge clk);
    idle_inputs();
    total_cnt++; if (bus.imem_we !== 1'b1) begin bad_cnt++; $display("[TB] FAIL b2b_we1: got %b want 1", bus.imem_we); end
    total_cnt++; if (count !== 9'd2) begin bad_cnt++; $display("[TB] FAIL b2b_count: got %0d want 2", count); end
    @(negedge clk);
  endtask

  task automatic test_full();
    do_start();
    for (int i = 0; i < DEPTH; i++) send_r(5'(i + 1), 1'b0, 8'(i));
    drive(FMT_R, 7'h01, 5'd1, 5'd1, 3'd1, 5'd1, OP_REG, 12'h0, 20'h0, 1'b0);
    #1;
    total_cnt++; if (bus.in_ready !== 1'b0) begin bad_cnt++; $display("[TB] FAIL full_ready: got %b want 0", bus.in_ready); end
    total_cnt++; if (done !== 1'b1) begin bad_cnt++; $display("[TB] FAIL full_done: got %b want 1", done); end
    total_cnt++; if (bus.imem_we !== 1'b1 || bus.imem_addr !== 8'd3) begin bad_cnt++; $display("[TB] FAIL full_last_write: got we=%b addr=%0d want we=1 addr=3", bus.imem_we, bus.imem_addr); end
    total_cnt++; if (count !== 9'd4) begin bad_cnt++; $display("[TB] FAIL full_count: got %0d want 4", count); end
    @(negedge clk);
    idle_inputs();
    total_cnt++; if (bus.imem_we !== 1'b0 || count !== 9'd4) begin bad_cnt++; $display("[TB] FAIL full_ignore: got we=%b count=%0d want we=0 count=4", bus.imem_we, count); end
  endtask

  task automatic test_bad_fmt();
    do_start();
    total_cnt++; if (err !== 1'b0) begin bad_cnt++; $display("[TB] FAIL bad_err_clear: got %b want 0", err); end
    send_r(5'd1, 1'b0, 8'd0);
    drive(FMT_BAD, 7'h7F, 5'd31, 5'd31, 3'd7, 5'd31, 7'h7F, 12'hFFF, 20'hFFFFF, 1'b0);
    @(negedge clk);
    total_cnt++; if (err !== 1'b1) begin bad_cnt++; $display("[TB] FAIL bad_err: got %b want 1", err); end
    total_cnt++; if (bus.imem_we !== 1'b0) begin bad_cnt++; $display("[TB] FAIL bad_nowrite: got %b want 0", bus.imem_we); end
    send_r(5'd2, 1'b0, 8'd1);
    idle_inputs();
    total_cnt++; if (bus.imem_we !== 1'b1 || bus.imem_addr !== 8'd1) begin bad_cnt++; $display("[TB] FAIL bad_next_addr: got we=%b addr=%0d want we=1 addr=1", bus.imem_we, bus.imem_addr); end
    total_cnt++; if (count !== 9'd2) begin bad_cnt++; $display("[TB] FAIL bad_count: got %0d want 2", count); end
    @(negedge clk);
  endtask

  task automatic test_last_and_restart();
    do_start();
    send_r(5'd4, 1'b0, 8'd0);
    drive(FMT_BAD, 7'h0, 5'd0, 5'd0, 3'd0, 5'd0, 7'h0, 12'h0, 20'h0, 1'b0);
    @(negedge clk);
    send_r(5'd6, 1'b1, 8'd1);
    idle_inputs();
    #1;
    total_cnt++; if ({done, err, bus.in_ready} !== 3'b110) begin bad_cnt++; $display("[TB] FAIL last_status: got done/err/ready=%b want 110", {done, err, bus.in_ready}); end
    total_cnt++; if (bus.imem_we !== 1'b1 || bus.imem_addr !== 8'd1) begin bad_cnt++; $display("[TB] FAIL last_write: got we=%b addr=%0d want we=1 addr=1", bus.imem_we, bus.imem_addr); end
    @(negedge clk);
    total_cnt++; if (done !== 1'b1 || count !== 9'd2) begin bad_cnt++; $display("[TB] FAIL last_hold: got done=%b count=%0d want done=1 count=2", done, count); end
    do_start();
    total_cnt++; if ({done, err} !== 2'b00 || count !== '0) begin bad_cnt++; $display("[TB] FAIL restart_clear: got done/err=%b count=%0d want 00 count=0", {done, err}, count); end
    send_r(5'd8, 1'b0, 8'd0);
    start = 1'b1;
    drive(FMT_U, 7'h0, 5'd0, 5'd0, 3'd0, 5'd9, OP_LUI, 12'h0, 20'hBEEF0, 1'b0);
    #1;
    total_cnt++; if (bus.in_ready !== 1'b0) begin bad_cnt++; $display("[TB] FAIL start_ready: got %b want 0", bus.in_ready); end
    @(negedge clk);
    start = 1'b0;
    idle_inputs();
    total_cnt++; if (bus.imem_we !== 1'b0 || count !== '0) begin bad_cnt++; $display("[TB] FAIL start_noaccept: got we=%b count=%0d want we=0 count=0", bus.imem_we, count); end
    send_r(5'd10, 1'b0, 8'd0);
    idle_inputs();
    total_cnt++; if (count !== 9'd1) begin bad_cnt++; $display("[TB] FAIL restart_count: got %0d want 1", count); end
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    do_start();
    send_r(5'd11, 1'b0, 8'd0);
    send_r(5'd12, 1'b0, 8'd1);
    drive(FMT_R, 7'h0, 5'd1, 5'd1, 3'd1, 5'd13, OP_REG, 12'h0, 20'h0, 1'b0);
    #2 rst = 1'b1;
    #1;
    total_cnt++; if ({bus.imem_we, done, err, busy, bus.in_ready} !== 5'b0) begin bad_cnt++; $display("[TB] FAIL arst_status: got %b want 00000", {bus.imem_we, done, err, busy, bus.in_ready}); end
    total_cnt++; if (bus.imem_addr !== '0 || bus.imem_wdata !== 32'h0 || count !== '0) begin bad_cnt++; $display("[TB] FAIL arst_data: got addr=%0d data=%h count=%0d want all 0", bus.imem_addr, bus.imem_wdata, count); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    total_cnt++; if (bus.in_ready !== 1'b0 || busy !== 1'b0) begin bad_cnt++; $display("[TB] FAIL arst_idle: got ready=%b busy=%b want 0 0", bus.in_ready, busy); end
    @(negedge clk);
    total_cnt++; if (bus.imem_we !== 1'b0) begin bad_cnt++; $display("[TB] FAIL arst_nowrite: got %b want 0", bus.imem_we); end
    idle_inputs();
    total_cnt++; if (exp_q.size() != 0) begin bad_cnt++; $display("[TB] FAIL scoreboard_drain: got %0d pending want 0", exp_q.size()); end
  endtask

  initial begin
    $display("[TB] starting instr_encode_loader bench");
    idle_inputs();
    drive(FMT_R, 7'h0, 5'd0, 5'd0, 3'd0, 5'd0, 7'h0, 12'h0, 20'h0, 1'b0);
    idle_inputs();
    test_reset();
    test_r_word();
    test_back_to_back();
    test_full();
    test_bad_fmt();
    test_last_and_restart();
    test_async_reset();
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
